// File: rtl/fft_out_reorder.sv
// Ping-pong reorder buffer for 16-point FFT results: natural-order words are written
// into one bank while the other bank streams out in bit-reversed address order.
module fft_out_reorder #(
   parameter int DATA_W = 16,
   parameter int N_LOG2 = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_push,
   input  logic signed [DATA_W-1:0] in_real,
   input  logic signed [DATA_W-1:0] in_imag,
   output logic                     in_stall,
   output logic                     out_push,
   output logic signed [DATA_W-1:0] out_real,
   output logic signed [DATA_W-1:0] out_imag,
   output logic [N_LOG2-1:0]        out_index,
   output logic                     out_last,
   input  logic                     out_stall,
   output logic                     drop_err
);

   localparam int N = 1 << N_LOG2;

   typedef enum logic {S_IDLE, S_STREAM} state_t;

   state_t                    state_q, state_d;
   logic                      wr_bank_q, wr_bank_d;
   logic                      rd_bank_q, rd_bank_d;
   logic [N_LOG2-1:0]         wr_cnt_q, wr_cnt_d;
   logic [N_LOG2-1:0]         rd_cnt_q, rd_cnt_d;
   logic [1:0]                bank_full_q, bank_full_d;
   logic                      drop_err_q, drop_err_d;
   logic                      out_push_q, out_push_d;
   logic signed [DATA_W-1:0]  out_real_q, out_real_d;
   logic signed [DATA_W-1:0]  out_imag_q, out_imag_d;
   logic [N_LOG2-1:0]         out_index_q, out_index_d;
   logic                      out_last_q, out_last_d;

   logic signed [DATA_W-1:0]  mem_re [2][N];
   logic signed [DATA_W-1:0]  mem_im [2][N];

   logic                      wr_en;
   logic                      loadable;
   logic                      load;
   logic [N_LOG2-1:0]         rd_addr;

   function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] a);
      logic [N_LOG2-1:0] r;
      for (int i = 0; i < N_LOG2; i++) begin
         r[i] = a[N_LOG2-1-i];
      end
      return r;
   endfunction

   assign in_stall = bank_full_q[wr_bank_q];
   assign wr_en    = in_push & ~in_stall;
   assign loadable = ~out_push_q | ~out_stall;
   assign rd_addr  = bitrev(rd_cnt_q);

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_re[wr_bank_q][wr_cnt_q] <= in_real;
         mem_im[wr_bank_q][wr_cnt_q] <= in_imag;
      end
   end

   always_comb begin
      state_d     = state_q;
      wr_bank_d   = wr_bank_q;
      rd_bank_d   = rd_bank_q;
      wr_cnt_d    = wr_cnt_q;
      rd_cnt_d    = rd_cnt_q;
      bank_full_d = bank_full_q;
      drop_err_d  = drop_err_q;
      out_push_d  = out_push_q;
      out_real_d  = out_real_q;
      out_imag_d  = out_imag_q;
      out_index_d = out_index_q;
      out_last_d  = out_last_q;
      load        = 1'b0;

      if (wr_en) begin
         wr_cnt_d = wr_cnt_q + N_LOG2'(1);
         if (wr_cnt_q == N_LOG2'(N-1)) begin
            bank_full_d[wr_bank_q] = 1'b1;
            wr_bank_d              = ~wr_bank_q;
         end
      end
      if (in_push & in_stall) begin
         drop_err_d = 1'b1;
      end

      // IDLE loads directly so the first word appears one edge after the bank fills
      case (state_q)
         S_IDLE: begin
            if (loadable) begin
               out_push_d = 1'b0;
            end
            if (bank_full_q[rd_bank_q]) begin
               state_d = S_STREAM;
               load    = loadable;
            end
         end
         S_STREAM: begin
            load = loadable;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (load) begin
         out_real_d  = mem_re[rd_bank_q][rd_addr];
         out_imag_d  = mem_im[rd_bank_q][rd_addr];
         out_index_d = rd_cnt_q;
         out_last_d  = (rd_cnt_q == N_LOG2'(N-1));
         out_push_d  = 1'b1;
         rd_cnt_d    = rd_cnt_q + N_LOG2'(1);
         if (rd_cnt_q == N_LOG2'(N-1)) begin
            bank_full_d[rd_bank_q] = 1'b0;
            rd_bank_d              = ~rd_bank_q;
            // Uses the post-write full bit so a frame finishing this edge streams gaplessly
            if (!bank_full_d[~rd_bank_q]) begin
               state_d = S_IDLE;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         wr_bank_q   <= 1'b0;
         rd_bank_q   <= 1'b0;
         wr_cnt_q    <= '0;
         rd_cnt_q    <= '0;
         bank_full_q <= 2'b00;
         drop_err_q  <= 1'b0;
         out_push_q  <= 1'b0;
         out_real_q  <= '0;
         out_imag_q  <= '0;
         out_index_q <= '0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_bank_q   <= wr_bank_d;
         rd_bank_q   <= rd_bank_d;
         wr_cnt_q    <= wr_cnt_d;
         rd_cnt_q    <= rd_cnt_d;
         bank_full_q <= bank_full_d;
         drop_err_q  <= drop_err_d;
         out_push_q  <= out_push_d;
         out_real_q  <= out_real_d;
         out_imag_q  <= out_imag_d;
         out_index_q <= out_index_d;
         out_last_q  <= out_last_d;
      end
   end

   assign out_push  = out_push_q;
   assign out_real  = out_real_q;
   assign out_imag  = out_imag_q;
   assign out_index = out_index_q;
   assign out_last  = out_last_q;
   assign drop_err  = drop_err_q;

endmodule

// File: tb/tb_fft_out_reorder.sv
// Scoreboard bench for fft_out_reorder: accepted input frames are turned into expected
// bit-reversed output words, and a negedge monitor compares every output transfer.
module tb_fft_out_reorder;
   localparam int DATA_W = 16;
   localparam int N_LOG2 = 4;
   localparam int N      = 16;

   logic                     clk = 1'b0;
   logic                     reset = 1'b1;
   logic                     in_push = 1'b0;
   logic signed [DATA_W-1:0] in_real = '0;
   logic signed [DATA_W-1:0] in_imag = '0;
   logic                     in_stall;
   logic                     out_push;
   logic signed [DATA_W-1:0] out_real;
   logic signed [DATA_W-1:0] out_imag;
   logic [N_LOG2-1:0]        out_index;
   logic                     out_last;
   logic                     out_stall = 1'b0;
   logic                     drop_err;

   fft_out_reorder #(.DATA_W(DATA_W), .N_LOG2(N_LOG2)) dut (
      .clk(clk), .reset(reset),
      .in_push(in_push), .in_real(in_real), .in_imag(in_imag), .in_stall(in_stall),
      .out_push(out_push), .out_real(out_real), .out_imag(out_imag),
      .out_index(out_index), .out_last(out_last), .out_stall(out_stall),
      .drop_err(drop_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] re;
      logic [15:0] im;
      logic [3:0]  idx;
      logic        last;
   } exp_t;

   int          n_checks = 0;
   int          n_fail   = 0;
   exp_t        exp_q[$];
   logic [31:0] frame[$];
   int          br_tab[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
   logic        exp_drop = 1'b0;
   logic        hold_pending = 1'b0;
   exp_t        held;
   exp_t        e;
   logic        prev_out_push = 1'b0;
   int          cyc = 0;
   int          last_push_cyc = 0;
   int          rise_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
      end
   endtask

   // Reference model and output monitor
   always @(negedge clk) begin
      if (reset) begin
         frame.delete();
         exp_q.delete();
         exp_drop     = 1'b0;
         hold_pending = 1'b0;
         prev_out_push = 1'b0;
      end else begin
         chk("drop_err", 32'(drop_err), 32'(exp_drop));
         if (in_push && in_stall) exp_drop = 1'b1;
         if (in_push && !in_stall) begin
            frame.push_back({in_real, in_imag});
            if (frame.size() == N) begin
               for (int k = 0; k < N; k++) begin
                  e.re   = frame[br_tab[k]][31:16];
                  e.im   = frame[br_tab[k]][15:0];
                  e.idx  = 4'(k);
                  e.last = (k == N-1);
                  exp_q.push_back(e);
               end
               frame.delete();
               last_push_cyc = cyc;
            end
         end
         if (out_push && !prev_out_push) rise_cyc = cyc;
         if (out_push) begin
            if (hold_pending) begin
               chk("hold_data", {out_real, out_imag}, {held.re, held.im});
               chk("hold_ctl", {27'd0, out_index, out_last}, {27'd0, held.idx, held.last});
            end
            if (!out_stall) begin
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_output: index %0d real %0h with no word expected",
                           out_index, out_real);
               end else begin
                  e = exp_q.pop_front();
                  chk("out_data", {out_real, out_imag}, {e.re, e.im});
                  chk("out_index", 32'(out_index), 32'(e.idx));
                  chk("out_last", 32'(out_last), 32'(e.last));
               end
               hold_pending = 1'b0;
            end else begin
               hold_pending = 1'b1;
               held = '{re: out_real, im: out_imag, idx: out_index, last: out_last};
            end
         end else if (hold_pending) begin
            chk("hold_push", 32'(out_push), 32'd1);
            hold_pending = 1'b0;
         end
         prev_out_push = out_push;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [15:0] r, input logic [15:0] im);
      int t = 0;
      while (in_stall && t < 200) begin
         in_push = 1'b0;
         step();
         t++;
      end
      if (t >= 200) chk("push_timeout", 32'd1, 32'd0);
      in_real = r;
      in_imag = im;
      in_push = 1'b1;
      step();
      in_push = 1'b0;
   endtask

   task automatic wait_drain(input bit rnd);
      int t = 0;
      while ((exp_q.size() != 0 || out_push) && t < 2000) begin
         if (rnd) out_stall = 1'($urandom % 2);
         step();
         t++;
      end
      out_stall = 1'b0;
      chk("drain_timeout", 32'(t < 2000), 32'd1);
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      in_push = 1'b0;
      step();
      reset = 1'b0;
      chk("rst_out_push", 32'(out_push), 32'd0);
      chk("rst_out_data", {out_real, out_imag}, 32'd0);
      chk("rst_out_ctl", {27'd0, out_index, out_last}, 32'd0);
      chk("rst_in_stall", 32'(in_stall), 32'd0);
      chk("rst_drop_err", 32'(drop_err), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      step();
      // 1: ramp frame, fixed latency
      do_reset();
      out_stall = 1'b0;
      for (int i = 0; i < N; i++) push_word(16'(i), 16'(-i));
      wait_drain(1'b0);
      chk("latency", 32'(rise_cyc - last_push_cyc), 32'd2);

      // 2: three frames with downstream stalled
      do_reset();
      out_stall = 1'b1;
      for (int i = 0; i < 2*N; i++) begin
         chk("no_stall_fill", 32'(in_stall), 32'd0);
         push_word(16'($urandom), 16'($urandom));
      end
      for (int i = 0; i < 3; i++) begin
         chk("stall_full", 32'(in_stall), 32'd1);
         step();
      end
      out_stall = 1'b0;
      fork
         for (int i = 0; i < N; i++) push_word(16'($urandom), 16'($urandom));
         for (int i = 0; i < 2*N; i++) begin
            chk("gapless_t2", 32'(out_push), 32'd1);
            step();
         end
      join
      wait_drain(1'b0);

      // 3: random backpressure
      do_reset();
      for (int i = 0; i < N; i++) begin
         out_stall = 1'($urandom % 2);
         push_word(16'($urandom), 16'($urandom));
      end
      wait_drain(1'b1);

      // 4: push while stalled
      do_reset();
      out_stall = 1'b1;
      for (int i = 0; i < 2*N; i++) push_word(16'($urandom), 16'($urandom));
      chk("stall_t4", 32'(in_stall), 32'd1);
      in_real = 16'hDEAD;
      in_imag = 16'hBEEF;
      in_push = 1'b1;
      for (int i = 0; i < 3; i++) step();
      in_push = 1'b0;
      chk("drop_set", 32'(drop_err), 32'd1);
      out_stall = 1'b0;
      wait_drain(1'b0);
      chk("drop_sticky", 32'(drop_err), 32'd1);

      // 5: reset mid-fill and mid-drain
      do_reset();
      for (int i = 0; i < 7; i++) push_word(16'($urandom), 16'($urandom));
      do_reset();
      for (int i = 0; i < N; i++) push_word(16'($urandom), 16'($urandom));
      t = 0;
      while (!(out_push && out_index == 4'd5) && t < 100) begin
         step();
         t++;
      end
      chk("reach_idx5", 32'(out_index), 32'd5);
      do_reset();
      for (int i = 0; i < N; i++) push_word(16'($urandom), 16'($urandom));
      wait_drain(1'b0);

      // 6: continuous 4 frames
      do_reset();
      fork
         for (int i = 0; i < 4*N; i++) begin
            chk("no_stall_t6", 32'(in_stall), 32'd0);
            push_word(16'($urandom), 16'($urandom));
         end
         begin
            int w = 0;
            while (!out_push && w < 100) begin
               step();
               w++;
            end
            for (int i = 0; i < 4*N; i++) begin
               chk("gapless_t6", 32'(out_push), 32'd1);
               step();
            end
         end
      join
      wait_drain(1'b0);

      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
